// File: rtl/shake_sponge.sv
// SHAKE128/SHAKE256 sponge controller: absorbs 64-bit message words with padding,
// hands the state to an external Keccak-f[1600] core and squeezes 64-bit lanes.
module shake_sponge #(
    parameter int unsigned OLEN_W   = 16,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                mode,
    input  logic [OLEN_W-1:0]   out_len,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [63:0]         in_data,
    input  logic                in_last,
    input  logic [2:0]          in_bytes,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [63:0]         out_data,
    output logic                out_last,
    output logic                perm_start,
    output logic [1599:0]       perm_state_out,
    input  logic [1599:0]       perm_state_in,
    input  logic                perm_done,
    output logic                busy,
    output logic                done,
    output logic                error
);
    localparam int unsigned LANES  = 25;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [63:0] PAD_END = 64'h8000_0000_0000_0000;

    typedef enum logic [1:0] {IDLE, ABSORB, PERM, SQUEEZE} state_t;

    state_t             state;
    logic [63:0]        lane [LANES];
    logic               mode_q;
    logic               phase_sq;
    logic [OLEN_W-1:0]  out_len_q;
    logic [OLEN_W-1:0]  remaining;
    logic [IDX_W-1:0]   lane_idx;
    logic [IDX_W-1:0]   sq_idx;
    logic [IDX_W-1:0]   rate_m1;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [63:0]        byte_mask;
    logic [63:0]        absorb_word;
    logic [63:0]        absorb_xor [LANES];

    assign rate_m1     = mode_q ? IDX_W'(16) : IDX_W'(20);
    assign byte_mask   = ~({64{1'b1}} << {in_bytes, 3'b000});
    assign absorb_word = in_last ? ((in_data & byte_mask) ^ (64'h1F << {in_bytes, 3'b000}))
                                 : in_data;

    assign in_ready  = (state == ABSORB);
    assign busy      = (state != IDLE);
    assign out_valid = (state == SQUEEZE) && (remaining != '0);
    assign out_last  = out_valid && (remaining == OLEN_W'(1));
    assign out_data  = lane[sq_idx];

    // Per-lane XOR contribution of the current absorb word, including both pad bytes
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            absorb_xor[i] = '0;
            if (IDX_W'(i) == lane_idx) begin
                absorb_xor[i] = absorb_word;
            end
            if (in_last && (IDX_W'(i) == rate_m1)) begin
                absorb_xor[i] = absorb_xor[i] ^ PAD_END;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            perm_state_out[64*i +: 64] = lane[i];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            mode_q     <= 1'b0;
            phase_sq   <= 1'b0;
            out_len_q  <= '0;
            remaining  <= '0;
            lane_idx   <= '0;
            sq_idx     <= '0;
            wait_cnt   <= '0;
            perm_start <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                lane[i] <= '0;
            end
        end else begin
            perm_start <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q    <= mode;
                        out_len_q <= out_len;
                        lane_idx  <= '0;
                        state     <= ABSORB;
                        for (int i = 0; i < LANES; i++) begin
                            lane[i] <= '0;
                        end
                    end
                end
                ABSORB: begin
                    if (in_valid) begin
                        for (int i = 0; i < LANES; i++) begin
                            lane[i] <= lane[i] ^ absorb_xor[i];
                        end
                        if (in_last) begin
                            phase_sq   <= 1'b1;
                            sq_idx     <= '0;
                            remaining  <= out_len_q;
                            lane_idx   <= '0;
                            wait_cnt   <= '0;
                            perm_start <= 1'b1;
                            state      <= PERM;
                        end else if (lane_idx == rate_m1) begin
                            phase_sq   <= 1'b0;
                            lane_idx   <= '0;
                            wait_cnt   <= '0;
                            perm_start <= 1'b1;
                            state      <= PERM;
                        end else begin
                            lane_idx <= lane_idx + IDX_W'(1);
                        end
                    end
                end
                PERM: begin
                    if (perm_done) begin
                        for (int i = 0; i < LANES; i++) begin
                            lane[i] <= perm_state_in[64*i +: 64];
                        end
                        if (!phase_sq) begin
                            state <= ABSORB;
                        end else if (remaining == '0) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            state <= SQUEEZE;
                        end
                    end else if ((MAX_WAIT != 0) && (wait_cnt == WAIT_W'(MAX_WAIT - 1))) begin
                        error <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                SQUEEZE: begin
                    if (out_ready) begin
                        remaining <= remaining - OLEN_W'(1);
                        if (remaining == OLEN_W'(1)) begin
                            sq_idx <= '0;
                            done   <= 1'b1;
                            state  <= IDLE;
                        end else if (sq_idx == rate_m1) begin
                            sq_idx     <= '0;
                            phase_sq   <= 1'b1;
                            wait_cnt   <= '0;
                            perm_start <= 1'b1;
                            state      <= PERM;
                        end else begin
                            sq_idx <= sq_idx + IDX_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
